// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the pipeline memory stage: FSM state
// encoding, default address map / timeout, and the timeout poison word.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int          DEFAULT_ADDR_W    = 6;
  localparam int          DEFAULT_TIMEOUT   = 255;
  localparam logic [31:0] POISON_WORD       = 32'hDEADBEEF;

endpackage

// File: rtl/mem_wb_stage_registers.sv
// MEM/WB pipeline register. While the stage is frozen it injects a bubble
// (write-back and read enables cleared) and holds the data fields.
module mem_wb_stage_registers (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_d,
  input  logic        mem_r_en_d,
  input  logic        mem_w_en_d,
  input  logic [31:0] alu_result_d,
  input  logic [31:0] rdata,
  input  logic [4:0]  dest_d,
  output logic        wb_en_q,
  output logic        mem_r_en_q,
  output logic [31:0] alu_result_q,
  output logic [31:0] read_value_q,
  output logic [4:0]  dest_q
);

  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      alu_result_q <= '0;
      read_value_q <= '0;
      dest_q       <= '0;
    end else if (freeze) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
    end else begin
      wb_en_q      <= wb_en_d;
      mem_r_en_q   <= mem_r_en_d;
      alu_result_q <= alu_result_d;
      dest_q       <= dest_d;
      // A simultaneous write enable turns the access into a store.
      read_value_q <= (mem_r_en_d && !mem_w_en_d) ? rdata : '0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: req/ack data-memory access FSM, address mapping,
// upstream freeze and MEM/WB register. Define MEM_TIMEOUT_EN to add the
// BUSY timeout with poisoned read data and a sticky mem_err flag.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          ADDR_W    = DEFAULT_ADDR_W,
  parameter int          TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       ST_val_in,
  input  logic [4:0]        Dest_in,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic [31:0]       ALU_result,
  output logic [31:0]       MEM_read_value,
  output logic [4:0]        Dest,
  output logic              mem_err
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mem_stage: TIMEOUT must be at least 1");
  end

  mem_state_e  state, state_next;
  logic        access;
  logic        timeout_abort;
  logic [31:0] rdata_q;

  assign access    = MEM_R_EN_in | MEM_W_EN_in;
  assign mem_we    = MEM_W_EN_in;
  assign mem_wdata = ST_val_in;
  // Modulo-2^32 offset from the window base; byte-lane bits are dropped.
  assign mem_addr  = ADDR_W'((ALU_result_in - BASE_ADDR) >> 2);

  // NOTE: the FSM resets to IDLE, but IDLE with access would still raise
  // req/freeze, so both are gated by rst to drop the instant reset asserts.
  assign mem_req = rst & (((state == IDLE) & access) | (state == BUSY));
  assign freeze  = rst & access & (state != DONE);

  // NOTE: next-state is assigned a default first so every path through the
  // case drives it and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (access) state_next = mem_ack ? DONE : BUSY;
      BUSY: if (mem_ack || timeout_abort) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (mem_req && mem_ack && !mem_we) begin
      rdata_q <= mem_rdata;
    end else if (timeout_abort) begin
      rdata_q <= POISON_WORD;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] busy_cnt;
  logic             mem_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                busy_cnt <= '0;
    else if (state == BUSY)  busy_cnt <= busy_cnt + 1'b1;
    else                     busy_cnt <= '0;
  end

  // A late ack in the final BUSY cycle still wins over the abort.
  assign timeout_abort = (state == BUSY) & ~mem_ack &
                         (busy_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               mem_err_q <= 1'b0;
    else if (timeout_abort) mem_err_q <= 1'b1;
  end

  assign mem_err = mem_err_q;
`else
  assign timeout_abort = 1'b0;
  assign mem_err       = 1'b0;
`endif

  mem_wb_stage_registers u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .wb_en_d      (WB_EN_in),
    .mem_r_en_d   (MEM_R_EN_in),
    .mem_w_en_d   (MEM_W_EN_in),
    .alu_result_d (ALU_result_in),
    .rdata        (rdata_q),
    .dest_d       (Dest_in),
    .wb_en_q      (WB_EN),
    .mem_r_en_q   (MEM_R_EN),
    .alu_result_q (ALU_result),
    .read_value_q (MEM_read_value),
    .dest_q       (Dest)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: fixed vector table, randomized
// instruction stream against a word-array memory model, reset and timeout cases.
module tb_mem_stage;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [31:0] ALU_result_in, ST_val_in;
  logic [4:0]  Dest_in;
  logic        freeze, mem_req, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        WB_EN, MEM_R_EN;
  logic [31:0] ALU_result, MEM_read_value;
  logic [4:0]  Dest;
  logic        mem_err;

  always #5 clk = ~clk;

  mem_stage #(.BASE_ADDR(32'd1024), .ADDR_W(6), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in), .Dest_in(Dest_in),
    .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
    .MEM_read_value(MEM_read_value), .Dest(Dest), .mem_err(mem_err)
  );

  typedef struct {
    logic        wb, r, w;
    logic [31:0] alu, st;
    logic [4:0]  dest;
    int          k;        // wait cycles before ack; >= 1000 means never
    int          exp_frz;  // cycles with freeze high
    logic [31:0] exp_rv;   // MEM_read_value once written back
  } vec_t;

  logic [31:0] ram     [DEPTH];  // memory seen by the DUT
  logic [31:0] ref_mem [DEPTH];  // expected memory contents
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Word index inside the 64-word window, from plain unsigned arithmetic.
  function automatic int model_addr(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off / 32'd4) % 32'(DEPTH));
  endfunction

  // Builds a vector whose expectations come from the reference memory.
  function automatic vec_t model_vec(input logic wb, input logic r, input logic w,
                                     input logic [31:0] alu, input logic [31:0] st,
                                     input logic [4:0] dest, input int k);
    vec_t v;
    v.wb = wb; v.r = r; v.w = w; v.alu = alu; v.st = st; v.dest = dest; v.k = k;
    v.exp_frz = (r || w) ? 1 + k : 0;
    v.exp_rv  = (r && !w) ? ref_mem[model_addr(alu)] : 32'd0;
    return v;
  endfunction

  task automatic run_instr(input vec_t v, input string name);
    int   a, frz_cycles, waits;
    bit   captured, was_frozen;
    a = model_addr(v.alu);
    frz_cycles = 0; waits = 0; captured = 0;
    @(negedge clk);
    WB_EN_in = v.wb; MEM_R_EN_in = v.r; MEM_W_EN_in = v.w;
    ALU_result_in = v.alu; ST_val_in = v.st; Dest_in = v.dest; mem_ack = 1'b0;
    for (int cyc = 0; cyc < 64 && !captured; cyc++) begin
      #1;
      was_frozen = (freeze === 1'b1);
      if (was_frozen) begin
        frz_cycles++;
        check({name, " req"},   32'(mem_req),   32'd1);
        check({name, " addr"},  32'(mem_addr),  32'(a));
        check({name, " we"},    32'(mem_we),    32'(v.w));
        check({name, " wdata"}, mem_wdata,      v.st);
        if (waits == v.k) begin
          mem_ack = 1'b1;
          if (mem_we) ram[mem_addr] = mem_wdata;
          else        mem_rdata = ram[mem_addr];
        end
        waits++;
      end else begin
        check({name, " req idle"}, 32'(mem_req), 32'd0);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!was_frozen) begin
        captured = 1;
      end else begin
        check({name, " bubble"}, 32'({WB_EN, MEM_R_EN}), 32'd0);
        @(negedge clk);
      end
    end
    check({name, " completes"}, 32'(captured), 32'd1);
    check({name, " freeze cycles"}, 32'(frz_cycles), 32'(v.exp_frz));
    check({name, " WB_EN"},      32'(WB_EN),    32'(v.wb));
    check({name, " MEM_R_EN"},   32'(MEM_R_EN), 32'(v.r));
    check({name, " ALU_result"}, ALU_result,    v.alu);
    check({name, " Dest"},       32'(Dest),     32'(v.dest));
    check({name, " read value"}, MEM_read_value, v.exp_rv);
    if (v.w && v.k < 1000) ref_mem[a] = v.st;
  endtask

  task automatic idle_inputs();
    WB_EN_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
    ALU_result_in = '0; ST_val_in = '0; Dest_in = '0;
  endtask

  vec_t fixed [9];
  vec_t v;

  initial begin
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom();
    ram[2] = 32'h1234; ram[63] = 32'h6363;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = ram[i];

    // Reset state, including req/freeze held low with an access pending.
    MEM_R_EN_in = 1'b1;
    #12;
    check("reset freeze",  32'(freeze),  32'd0);
    check("reset req",     32'(mem_req), 32'd0);
    check("reset outputs", {30'd0, WB_EN, MEM_R_EN}, 32'd0);
    check("reset rv",      MEM_read_value, 32'd0);
    check("reset alu",     ALU_result, 32'd0);
    check("reset err",     32'(mem_err), 32'd0);
    idle_inputs();
    @(negedge clk); rst = 1'b1;

    //             wb r  w  alu          st            dest k  frz rv
    fixed[0] = '{1, 0, 0, 32'h55,      32'h0,        3,   0, 0, 32'h0};
    fixed[1] = '{1, 1, 0, 32'h408,     32'h0,        5,   0, 1, 32'h1234};
    fixed[2] = '{0, 0, 1, 32'h40C,     32'hCAFE,     0,   3, 4, 32'h0};
    fixed[3] = '{1, 1, 0, 32'h40C,     32'h0,        6,   1, 2, 32'hCAFE};
    fixed[4] = '{1, 1, 1, 32'h410,     32'hBEEF,     8,   0, 1, 32'h0};
    fixed[5] = '{1, 1, 0, 32'h410,     32'h0,        9,   2, 3, 32'hBEEF};
    fixed[6] = '{1, 1, 0, 32'h3FC,     32'h0,        10,  0, 1, 32'h6363};
    fixed[7] = '{1, 1, 0, 32'h40B,     32'h0,        11,  1, 2, 32'h1234};
    fixed[8] = '{0, 0, 0, 32'hFFFFFFFF, 32'h0,       31,  0, 0, 32'h0};
    for (int i = 0; i < 9; i++) run_instr(fixed[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [31:0] alu;
      kind = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) alu = $urandom();
      else alu = 32'd1024 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      v = model_vec(1'($urandom()), kind == 1 || kind == 3, kind >= 2, alu,
                    $urandom(), 5'($urandom()), $urandom_range(0, 3));
      run_instr(v, $sformatf("rnd%0d", i));
    end

    // Reset while BUSY abandons the access; the next load runs normally.
    @(negedge clk);
    WB_EN_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 0; ALU_result_in = 32'h414; Dest_in = 7;
    repeat (2) @(negedge clk);
    #1;
    check("busy req",    32'(mem_req), 32'd1);
    check("busy freeze", 32'(freeze),  32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst busy req",    32'(mem_req), 32'd0);
    check("rst busy freeze", 32'(freeze),  32'd0);
    check("rst busy alu",    ALU_result,   32'd0);
    check("rst busy dest",   32'(Dest),    32'd0);
    check("rst busy rv",     MEM_read_value, 32'd0);
    idle_inputs();
    @(negedge clk); rst = 1'b1;
    run_instr(model_vec(1, 1, 0, 32'h414, 32'h0, 7, 1), "after reset");

`ifdef MEM_TIMEOUT_EN
    run_instr('{1, 1, 0, 32'h420, 32'h0, 12, 1000, 5, 32'hDEADBEEF}, "timeout");
    check("timeout err", 32'(mem_err), 32'd1);
    run_instr(model_vec(1, 0, 0, 32'h77, 32'h0, 4, 0), "post timeout");
    check("err sticky", 32'(mem_err), 32'd1);
    @(negedge clk); rst = 1'b0;
    #1 check("err cleared", 32'(mem_err), 32'd0);
    @(negedge clk); rst = 1'b1;
`else
    check("err tied low", 32'(mem_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage pipeline, directly downstream of the EXE/MEM pipeline registers. Loads and stores go to an external word-addressed data memory through a req/ack handshake, and the block freezes the upstream pipeline until the access completes. The results go into its own MEM/WB output registers, which feed write-back. Non-memory instructions pass through in one cycle.

## Interface
- BASE_ADDR, 32'd1024, byte address mapped to data-memory word 0
- ADDR_W, 6, data-memory word-address width
- TIMEOUT, 255, maximum BUSY cycles before abort (used only with the macro)

- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control from the EXE/MEM registers
- ALU_result_in  in  32  effective byte address, or ALU result
- ST_val_in  in  32  store data
- Dest_in  in  5  destination register
- freeze  out  1  holds PC, IF/ID, ID/EXE and EXE/MEM when high
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_ack  in  1  access complete; rdata is valid in the same cycle
- mem_rdata  in  32  read data
- WB_EN, MEM_R_EN  out  1  MEM/WB register
- ALU_result, MEM_read_value  out  32  MEM/WB register
- Dest  out  5  MEM/WB register
- mem_err  out  1  sticky timeout flag

## Operation
- access = MEM_R_EN_in | MEM_W_EN_in. When both enables are set, the write wins: mem_we=1 and MEM_read_value=0.
- mem_addr = (ALU_result_in − BASE_ADDR) >> 2, truncated to ADDR_W. Subtraction is modulo 2^32. The low two bits are ignored, so there is no misalignment trap.
- mem_wdata = ST_val_in. mem_we = MEM_W_EN_in.
- FSM states are IDLE, BUSY and DONE.
  - IDLE with access: mem_req=1. On mem_ack go to DONE, otherwise go to BUSY.
  - BUSY: mem_req=1. On mem_ack go to DONE.
  - DONE: mem_req=0. Go to IDLE.
  - IDLE without access: stay in IDLE.
- rdata_q captures mem_rdata on every edge where mem_req & mem_ack & ~mem_we.
- freeze = access & (state != DONE), combinational.
- MEM/WB register, on each edge:
  - freeze=0: capture WB_EN_in, MEM_R_EN_in, ALU_result_in, Dest_in. MEM_read_value gets rdata_q if this is a read, otherwise 0.
  - freeze=1: insert a bubble. WB_EN<=0 and MEM_R_EN<=0; other fields hold.
- mem_ack outside a request is ignored.

## Timing
- Reset: FSM goes to IDLE; all MEM/WB outputs, rdata_q and mem_err clear to 0. mem_req and freeze drop immediately, asynchronously.
- Reset during BUSY abandons the access. The memory must tolerate a dropped request.
- Non-memory instruction: MEM/WB updates at the next edge, latency 1.
- Access acked in its first cycle:
  - cycle 0 (IDLE): freeze=1, req=1, ack=1.
  - cycle 1 (DONE): freeze=0.
  - MEM/WB updates at the end of cycle 1.
  - Latency is 2, with one bubble.
- Access with ack after k wait cycles: latency is 2+k; freeze is high for 1+k cycles.
- Back-to-back accesses: DONE always returns to IDLE, so there are no merged requests. Each access costs at least 2 cycles.
- While mem_req is high, the request fields are stable, because upstream is frozen.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8+ bit counter runs in BUSY.
  - After TIMEOUT BUSY cycles without ack: drop the request, go to DONE, load rdata_q=32'hDEADBEEF, set mem_err.
  - mem_err stays set until reset.
- MEM_TIMEOUT_EN undefined:
  - No counter; BUSY waits indefinitely.
  - mem_err is tied to 0. The port still exists.

## Structure
- Package mem_stage_pkg holds the state enum (IDLE/BUSY/DONE), the BASE_ADDR and TIMEOUT defaults, and the poison constant 32'hDEADBEEF.
- Sub-module mem_wb_stage_registers holds the MEM/WB register with freeze/bubble behaviour. The FSM, address mapping and timeout logic stay in mem_stage.

## Test plan
- ALU add, ALU_result_in=0x55, Dest=3, WB_EN_in=1 -> next edge: WB_EN=1, ALU_result=0x55, Dest=3, freeze never high.
- Load at 0x408, memory acks in the first cycle with 0x1234 -> mem_addr=2, freeze high 1 cycle, one bubble, then MEM_read_value=0x1234 and MEM_R_EN=1.
- Store at 0x40C, ST_val=0xCAFE, ack after 3 wait cycles -> mem_we=1, mem_addr=3, mem_wdata=0xCAFE held stable, freeze high 4 cycles, MEM_read_value=0.
- Reset asserted during BUSY -> mem_req and freeze drop immediately, outputs 0; after release, the FSM is IDLE and a new load completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT=4, load never acked -> abort after 4 BUSY cycles, MEM_read_value=0xDEADBEEF, mem_err=1 until reset.
- MEM_R_EN_in=MEM_W_EN_in=1 -> write issued, MEM_read_value=0.
